soc_mem_io: RTL and testbench
=============================

// Module: soc_mem_io
// PURPOSE
// - Parametrised successor of the SOC memory: byte-masked read/write word RAM plus a memory-mapped IO page
//   (LEDs, free-running cycle counter, timer compare with sticky IRQ), behind one processor bus.
// - Adds configurable wait states with rbusy/wbusy handshake; sits between Processor and board pins in SOC.
// PARAMETERS
// - DEPTH        1024  RAM depth in 32-bit words, power of two, >=16
// - WAIT_STATES  0     extra cycles per access, 0..7; 0 = single-cycle RAM timing
// - N_LEDS       4     width of LED output register, 1..32
// - IO_BIT       22    address bit selecting IO page (1 = IO, 0 = RAM)
// - INIT_FILE    ""    $readmemh image for RAM; empty = no preload
// PORTS
// - clk        in   1       system clock
// - reset_n    in   1       synchronous reset, active-low
// - mem_addr   in   32      byte address; bits [1:0] ignored
// - mem_rstrb  in   1       read request, one-cycle pulse
// - mem_wdata  in   32      write data, lane-aligned
// - mem_wmask  in   4       byte write enables; nonzero = write request
// - mem_rdata  out  32      read data
// - mem_rbusy  out  1       read in progress, rdata not yet valid
// - mem_wbusy  out  1       write in progress
// - leds       out  N_LEDS  LED register
// - timer_irq  out  1       sticky timer interrupt
// BEHAVIOUR
// - Reset (reset_n=0 at posedge): FSM->IDLE, pending access dropped, rdata=0, rbusy=wbusy=0, leds=0,
//   cycles=0, timecmp=0, irq=0. RAM contents retained. Reset mid-access aborts it; a pending write not yet committed is lost.
// - Clock enable: while reset_n=1 the clock is always active; there is no separate enable.
// - Accept: request taken only in IDLE; requests during BUSY ignored (master must hold off).
// - FSM IDLE->BUSY on accept when WAIT_STATES>0; BUSY counts down WAIT_STATES cycles, then ->IDLE.
//   rbusy/wbusy high from cycle after accept through last wait cycle.
// - Read latency: mem_rdata valid on cycle 1+WAIT_STATES after rstrb; held until next read completes.
//   WAIT_STATES=0: rdata valid next cycle, busy never asserted (identical to previous memory timing).
// - Write commit: at the final cycle of the access (accept cycle when WAIT_STATES=0); only lanes with wmask=1 change.
// - rstrb and wmask!=0 together: one access; write commits, rdata returns pre-write word.
// - RAM index = mem_addr[$clog2(DEPTH)+1:2]; higher bits (except IO_BIT) ignored -> wrap-around aliasing.
// - IO page, offset mem_addr[3:2]: 0 LEDS (RW, low N_LEDS bits, upper bits read 0);
//   1 CYCLES (RO, 32-bit, +1 every cycle, wraps 0xFFFFFFFF->0; writes ignored);
//   2 TIMECMP (RW); 3 STATUS (bit0 = irq; write 1 to bit0 clears, other bits read 0).
// - IO writes honour wmask per byte; IO reads follow same latency as RAM.
// - IRQ: set when cycles==timecmp and timecmp!=0; sticky. Set and clear in same cycle: set wins.
// - LED output driven directly from LEDS register (no extra stage).
// STRUCTURE
// - defines.v: IO offset constants (IO_LEDS=0, IO_CYCLES=1, IO_TIMECMP=2, IO_STATUS=3), FSM state codes.
// - Sub-module mem_bram: DEPTH x 32 synchronous RAM, 4 byte-write enables, registered read, INIT_FILE preload.
// - Top: access FSM + wait counter, IO registers, counter, irq, rdata mux (RAM vs IO selected by registered IO_BIT).
// TESTING
// - WAIT_STATES=0: write 0xDEADBEEF wmask=F @0x10, read @0x10 -> rdata=0xDEADBEEF next cycle, rbusy never high.
// - Byte mask: @0x10 write 0x000000AA wmask=0001 -> read 0xDEADBEAA; wmask=1000 data 0x11000000 -> 0x11ADBEAA.
// - WAIT_STATES=3: rstrb -> rbusy high 3 cycles, rdata valid cycle 4; second rstrb during busy ignored.
// - IO: write LEDS=0x5 -> leds=4'b0101; timecmp=100 -> irq rises at cycles==100, stays; STATUS write 1 clears.
// - Wrap: DEPTH=16, write @0x40 reads back at @0x00; force CYCLES near 0xFFFFFFFF via reset-free run -> wraps to 0.
// - Reset during BUSY with pending write -> outputs to reset values, target RAM word unchanged.

Source files
------------

// File: rtl/soc_mem_io_pkg.sv
// Shared constants, types and helpers for soc_mem_io.
// IO page offsets, access FSM states, read-source select, byte merge.
package soc_mem_io_pkg;

  localparam logic [1:0] IO_LEDS    = 2'd0;
  localparam logic [1:0] IO_CYCLES  = 2'd1;
  localparam logic [1:0] IO_TIMECMP = 2'd2;
  localparam logic [1:0] IO_STATUS  = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_RAM,
    RD_IO
  } rd_src_t;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  m
  );
    merge_bytes = old_w;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) merge_bytes[8*b +: 8] = new_w[8*b +: 8];
    end
  endfunction

endpackage

// File: rtl/soc_mem_io_bram.sv
// DEPTH x 32 synchronous RAM: per-byte write enables, registered read.
// Ports: clk, addr (word index), we[3:0], wdata, re, rdata (held when re=0).
module soc_mem_io_bram #(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [3:0]               we,
  input  logic [31:0]              wdata,
  input  logic                     re,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/soc_mem_io.sv
// Word RAM plus IO page (LEDs, cycle counter, timer IRQ) with wait states.
// Ports: clk, reset_n, mem_* processor bus, leds, timer_irq.
module soc_mem_io
  import soc_mem_io_pkg::*;
#(
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_STATES = 0,
  parameter int    N_LEDS      = 4,
  parameter int    IO_BIT      = 22,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       mem_addr,
  input  logic              mem_rstrb,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wmask,
  output logic [31:0]       mem_rdata,
  output logic              mem_rbusy,
  output logic              mem_wbusy,
  output logic [N_LEDS-1:0] leds,
  output logic              timer_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef logic [N_LEDS-1:0] led_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  rd_src_t     rd_src;
  logic        req, accept, fire, busy;

  logic [AW-1:0] lat_idx;
  logic          lat_io;
  logic [1:0]    lat_off;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_wmask;
  logic          lat_rd;

  logic [AW-1:0] op_idx;
  logic          op_io;
  logic [1:0]    op_off;
  logic [31:0]   op_wdata;
  logic [3:0]    op_wmask;
  logic          op_rd;

  logic [31:0] ram_q, io_q, io_rval;
  logic [31:0] cycles, timecmp;
  logic [3:0]  ram_we;
  logic        ram_re, io_wr;
  logic        irq_set, irq_clr;
  logic        unused_addr;

  assign unused_addr = ^mem_addr;

  assign req    = mem_rstrb | (|mem_wmask);
  assign busy   = (state == ST_BUSY);
  assign accept = (state == ST_IDLE) && req;

  // While waiting, the access runs on the values captured at accept.
  assign op_idx   = busy ? lat_idx   : mem_addr[AW+1:2];
  assign op_io    = busy ? lat_io    : mem_addr[IO_BIT];
  assign op_off   = busy ? lat_off   : mem_addr[3:2];
  assign op_wdata = busy ? lat_wdata : mem_wdata;
  assign op_wmask = busy ? lat_wmask : mem_wmask;
  assign op_rd    = busy ? lat_rd    : mem_rstrb;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fire      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req) begin
          if (WS == 3'd0) begin
            fire = 1'b1;
          end else begin
            state_nxt = ST_BUSY;
            cnt_nxt   = WS - 3'd1;
          end
        end
      end
      ST_BUSY: begin
        if (cnt == 3'd0) begin
          fire      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ram_we = (fire && reset_n && !op_io) ? op_wmask : 4'b0;
  assign ram_re = fire && reset_n && op_rd && !op_io;
  assign io_wr  = fire && op_io && (|op_wmask);

  soc_mem_io_bram #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_bram (
    .clk   (clk),
    .addr  (op_idx),
    .we    (ram_we),
    .wdata (op_wdata),
    .re    (ram_re),
    .rdata (ram_q)
  );

  always_comb begin
    io_rval = '0;
    unique case (op_off)
      IO_LEDS:    io_rval[N_LEDS-1:0] = leds;
      IO_CYCLES:  io_rval = cycles;
      IO_TIMECMP: io_rval = timecmp;
      IO_STATUS:  io_rval[0] = timer_irq;
      default:    io_rval = '0;
    endcase
  end

  assign irq_set = (cycles == timecmp) && (timecmp != '0);
  assign irq_clr = io_wr && (op_off == IO_STATUS) &&
                   op_wmask[0] && op_wdata[0];

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_idx   <= mem_addr[AW+1:2];
      lat_io    <= mem_addr[IO_BIT];
      lat_off   <= mem_addr[3:2];
      lat_wdata <= mem_wdata;
      lat_wmask <= mem_wmask;
      lat_rd    <= mem_rstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rd_src    <= RD_NONE;
      io_q      <= '0;
      leds      <= '0;
      cycles    <= '0;
      timecmp   <= '0;
      timer_irq <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cycles    <= cycles + 32'd1;
      timer_irq <= irq_set | (timer_irq & ~irq_clr);
      if (fire && op_rd) begin
        rd_src <= op_io ? RD_IO : RD_RAM;
        if (op_io) io_q <= io_rval;
      end
      if (io_wr && op_off == IO_LEDS) begin
        leds <= led_t'(merge_bytes(32'(leds), op_wdata, op_wmask));
      end
      if (io_wr && op_off == IO_TIMECMP) begin
        timecmp <= merge_bytes(timecmp, op_wdata, op_wmask);
      end
    end
  end

  always_comb begin
    mem_rdata = '0;
    unique case (rd_src)
      RD_RAM:  mem_rdata = ram_q;
      RD_IO:   mem_rdata = io_q;
      default: mem_rdata = '0;
    endcase
  end

  assign mem_rbusy = busy && lat_rd;
  assign mem_wbusy = busy && (|lat_wmask);

endmodule

// File: tb/tb_soc_mem_io.sv
// Directed bench for soc_mem_io: a zero-wait DEPTH=16 instance
// and a three-wait-state instance driven from one linear sequence.
module tb_soc_mem_io;

  localparam logic [31:0] IO = 32'h0040_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, rst_b_n;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_rstrb, a_rbusy, a_wbusy, a_irq;
  logic [3:0]  a_wmask, a_leds;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_rstrb, b_rbusy, b_wbusy, b_irq;
  logic [3:0]  b_wmask, b_leds;

  int   checks = 0;
  int   failures = 0;
  logic busy_seen_a = 1'b0;

  soc_mem_io #(.DEPTH(16), .WAIT_STATES(0)) u_a (
    .clk(clk), .reset_n(rst_a_n),
    .mem_addr(a_addr), .mem_rstrb(a_rstrb),
    .mem_wdata(a_wdata), .mem_wmask(a_wmask),
    .mem_rdata(a_rdata), .mem_rbusy(a_rbusy),
    .mem_wbusy(a_wbusy), .leds(a_leds),
    .timer_irq(a_irq)
  );

  soc_mem_io #(.DEPTH(1024), .WAIT_STATES(3)) u_b (
    .clk(clk), .reset_n(rst_b_n),
    .mem_addr(b_addr), .mem_rstrb(b_rstrb),
    .mem_wdata(b_wdata), .mem_wmask(b_wmask),
    .mem_rdata(b_rdata), .mem_rbusy(b_rbusy),
    .mem_wbusy(b_wbusy), .leds(b_leds),
    .timer_irq(b_irq)
  );

  always @(negedge clk) begin
    if (a_rbusy === 1'b1 || a_wbusy === 1'b1) busy_seen_a = 1'b1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [31:0] addr,
                      input logic [31:0] data,
                      input logic [3:0]  m);
    a_addr = addr; a_wdata = data; a_wmask = m;
    @(negedge clk);
    a_wmask = 4'h0;
  endtask

  task automatic rd_a(input logic [31:0] addr,
                      output logic [31:0] d);
    a_addr = addr; a_rstrb = 1'b1;
    @(negedge clk);
    a_rstrb = 1'b0;
    d = a_rdata;
  endtask

  initial begin
    logic [31:0] d, c1, c2;
    int hi, n;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    a_addr = '0; a_wdata = '0; a_wmask = '0; a_rstrb = 1'b0;
    b_addr = '0; b_wdata = '0; b_wmask = '0; b_rstrb = 1'b0;
    repeat (2) @(negedge clk);

    chk("a_rst_rdata", a_rdata, 32'h0);
    chk("a_rst_leds", 32'(a_leds), 32'h0);
    chk("a_rst_irq", 32'(a_irq), 32'h0);
    chk("b_rst_rdata", b_rdata, 32'h0);
    chk("b_rst_busy", 32'({b_rbusy, b_wbusy}), 32'h0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(negedge clk);

    wr_a(32'h10, 32'hDEADBEEF, 4'hF);
    rd_a(32'h10, d); chk("ram_full_word", d, 32'hDEADBEEF);
    wr_a(32'h10, 32'h000000AA, 4'h1);
    rd_a(32'h10, d); chk("ram_mask_b0", d, 32'hDEADBEAA);
    wr_a(32'h10, 32'h11000000, 4'h8);
    rd_a(32'h10, d); chk("ram_mask_b3", d, 32'h11ADBEAA);
    wr_a(32'h40, 32'h12345678, 4'hF);
    rd_a(32'h00, d); chk("ram_wrap_alias", d, 32'h12345678);
    rd_a(32'h10, d); chk("ram_no_clobber", d, 32'h11ADBEAA);

    a_addr = 32'h0; a_wdata = 32'hCAFEF00D;
    a_wmask = 4'hF; a_rstrb = 1'b1;
    @(negedge clk);
    a_wmask = 4'h0; a_rstrb = 1'b0;
    chk("rw_pre_write", a_rdata, 32'h12345678);
    rd_a(32'h0, d); chk("rw_committed", d, 32'hCAFEF00D);
    wr_a(32'h4, 32'h1, 4'hF);
    chk("rdata_held", a_rdata, 32'hCAFEF00D);

    wr_a(IO, 32'h5, 4'hF);
    chk("leds_5", 32'(a_leds), 32'h5);
    rd_a(IO, d); chk("leds_read", d, 32'h5);
    wr_a(IO, 32'hFFFFFFFF, 4'h1);
    chk("leds_f", 32'(a_leds), 32'hF);
    rd_a(IO, d); chk("leds_upper_zero", d, 32'hF);
    wr_a(IO, 32'h0, 4'h2);
    chk("leds_lane1_only", 32'(a_leds), 32'hF);

    rd_a(IO + 32'h4, c1);
    wr_a(IO + 32'h4, 32'h0, 4'hF);
    repeat (9) @(negedge clk);
    rd_a(IO + 32'h4, c2);
    chk("cycles_delta", c2 - c1, 32'd11);

    wr_a(IO + 32'h8, 32'd200, 4'hF);
    rd_a(IO + 32'h8, d); chk("timecmp_read", d, 32'd200);
    chk("irq_before", 32'(a_irq), 32'h0);
    n = 0;
    while (a_irq !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("irq_rise", 32'(a_irq), 32'h1);
    rd_a(IO + 32'h4, d); chk("cycles_at_irq", d, 32'd201);
    repeat (5) @(negedge clk);
    chk("irq_sticky", 32'(a_irq), 32'h1);
    rd_a(IO + 32'hC, d); chk("status_set", d, 32'h1);
    wr_a(IO + 32'hC, 32'h1, 4'h1);
    chk("irq_cleared", 32'(a_irq), 32'h0);
    rd_a(IO + 32'hC, d); chk("status_clr", d, 32'h0);
    chk("a_never_busy", 32'(busy_seen_a), 32'h0);

    b_addr = 32'h20; b_wdata = 32'h0BADCAFE; b_wmask = 4'hF;
    @(negedge clk);
    b_wmask = 4'h0;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (b_wbusy) hi++;
      @(negedge clk);
    end
    chk("b_wbusy_cycles", hi, 32'd3);

    b_addr = 32'h20; b_rstrb = 1'b1;
    @(negedge clk);
    b_rstrb = 1'b0;
    chk("b_rbusy_c1", 32'(b_rbusy), 32'h1);
    chk("b_rdata_pending", b_rdata, 32'h0);
    @(negedge clk);
    b_addr = 32'h24; b_rstrb = 1'b1;
    @(negedge clk);
    b_rstrb = 1'b0;
    chk("b_rbusy_c3", 32'(b_rbusy), 32'h1);
    @(negedge clk);
    chk("b_rbusy_c4", 32'(b_rbusy), 32'h0);
    chk("b_rdata_c4", b_rdata, 32'h0BADCAFE);
    @(negedge clk);
    chk("b_ignored_strobe", 32'(b_rbusy), 32'h0);
    repeat (4) @(negedge clk);
    chk("b_rdata_hold", b_rdata, 32'h0BADCAFE);

    b_addr = IO; b_wdata = 32'h3; b_wmask = 4'hF;
    @(negedge clk);
    b_wmask = 4'h0;
    repeat (3) @(negedge clk);
    chk("b_leds", 32'(b_leds), 32'h3);

    b_addr = 32'h20; b_wdata = 32'h55555555; b_wmask = 4'hF;
    @(negedge clk);
    b_wmask = 4'h0;
    chk("b_wbusy_pre_rst", 32'(b_wbusy), 32'h1);
    rst_b_n = 1'b0;
    @(negedge clk);
    chk("b_rst_busy_mid", 32'({b_rbusy, b_wbusy}), 32'h0);
    chk("b_rst_rdata_mid", b_rdata, 32'h0);
    chk("b_rst_leds_mid", 32'(b_leds), 32'h0);
    rst_b_n = 1'b1;
    repeat (2) @(negedge clk);
    b_addr = 32'h20; b_rstrb = 1'b1;
    @(negedge clk);
    b_rstrb = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_write_aborted", b_rdata, 32'h0BADCAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
